// File: rtl/mpf_tx_policy_shim.sv
// Two-channel request shim: per-channel FIFOs that tag each request with the policy
// bits in force at enqueue, meter in-flight reads and flag overflow/underflow.
module mpf_tx_policy_shim #(
  parameter int HDR_W         = 80,
  parameter int DATA_W        = 512,
  parameter int DEPTH         = 8,
  parameter int ALMFULL_SLACK = 4,
  parameter int MAX_RD_OUT    = 64,
  localparam int CW           = $clog2(MAX_RD_OUT + 1)
) (
  input  logic              pClk,
  input  logic              SoftReset_n,
  input  logic [2:0]        cfg_ext,
  input  logic              c0_in_valid,
  input  logic              c0_in_is_rd,
  input  logic [HDR_W-1:0]  c0_in_hdr,
  output logic              c0_almfull,
  output logic              c0_out_valid,
  output logic [HDR_W-1:0]  c0_out_hdr,
  output logic [2:0]        c0_out_ext,
  input  logic              fiu_c0_almfull,
  input  logic              c0_rsp_valid,
  input  logic              c1_in_valid,
  input  logic              c1_in_is_wr,
  input  logic [HDR_W-1:0]  c1_in_hdr,
  input  logic [DATA_W-1:0] c1_in_data,
  output logic              c1_almfull,
  output logic              c1_out_valid,
  output logic [HDR_W-1:0]  c1_out_hdr,
  output logic [DATA_W-1:0] c1_out_data,
  output logic [2:0]        c1_out_ext,
  input  logic              fiu_c1_almfull,
  output logic [CW-1:0]     rd_outstanding,
  output logic [1:0]        err_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);
  localparam logic [NW-1:0] AF_THR_N = NW'(DEPTH - ALMFULL_SLACK);
  localparam logic [CW-1:0] MAX_RD_C = CW'(MAX_RD_OUT);

  logic [HDR_W-1:0]  c0_hdr_mem_r [DEPTH];
  logic [2:0]        c0_ext_mem_r [DEPTH];
  logic              c0_rd_mem_r  [DEPTH];
  logic [HDR_W-1:0]  c1_hdr_mem_r [DEPTH];
  logic [DATA_W-1:0] c1_data_mem_r[DEPTH];
  logic [2:0]        c1_ext_mem_r [DEPTH];

  logic [AW-1:0]     c0_wptr_r, c0_rptr_r, c1_wptr_r, c1_rptr_r;
  logic [NW-1:0]     c0_count_r, c0_count_nxt_s, c1_count_r, c1_count_nxt_s;
  logic              c0_head_rd_s, c0_deq_s, c0_enq_s, c0_ovf_s, c0_rd_deq_s;
  logic              c1_deq_s, c1_enq_s, c1_ovf_s;
  logic [CW-1:0]     rd_out_r, rd_out_nxt_s;
  logic              udf_s;
  logic [1:0]        err_r;

  logic              c0_out_valid_r, c1_out_valid_r, c0_almfull_r, c1_almfull_r;
  logic [HDR_W-1:0]  c0_out_hdr_r, c1_out_hdr_r;
  logic [2:0]        c0_out_ext_r, c1_out_ext_r;
  logic [DATA_W-1:0] c1_out_data_r;

  // Read channel: a read at the head waits while the in-flight cap is reached
  always_comb begin
    c0_head_rd_s = c0_rd_mem_r[c0_rptr_r];
    c0_deq_s     = (c0_count_r != '0) && !fiu_c0_almfull &&
                   (!c0_head_rd_s || (rd_out_r < MAX_RD_C));
    c0_enq_s     = c0_in_valid && ((c0_count_r < DEPTH_N) || c0_deq_s);
    c0_ovf_s     = c0_in_valid && !c0_enq_s;
    c0_rd_deq_s  = c0_deq_s && c0_head_rd_s;
    case ({c0_enq_s, c0_deq_s})
      2'b10:   c0_count_nxt_s = c0_count_r + NW'(1'b1);
      2'b01:   c0_count_nxt_s = c0_count_r - NW'(1'b1);
      default: c0_count_nxt_s = c0_count_r;
    endcase
  end

  // Write channel dequeue/enqueue decisions
  always_comb begin
    c1_deq_s = (c1_count_r != '0) && !fiu_c1_almfull;
    c1_enq_s = c1_in_valid && ((c1_count_r < DEPTH_N) || c1_deq_s);
    c1_ovf_s = c1_in_valid && !c1_enq_s;
    case ({c1_enq_s, c1_deq_s})
      2'b10:   c1_count_nxt_s = c1_count_r + NW'(1'b1);
      2'b01:   c1_count_nxt_s = c1_count_r - NW'(1'b1);
      default: c1_count_nxt_s = c1_count_r;
    endcase
  end

  // In-flight read accounting; a response with nothing outstanding is an underflow
  always_comb begin
    rd_out_nxt_s = rd_out_r;
    udf_s        = 1'b0;
    case ({c0_rd_deq_s, c0_rsp_valid})
      2'b10: rd_out_nxt_s = rd_out_r + CW'(1'b1);
      2'b01: begin
        if (rd_out_r == '0) begin
          udf_s = 1'b1;
        end else begin
          rd_out_nxt_s = rd_out_r - CW'(1'b1);
        end
      end
      default: rd_out_nxt_s = rd_out_r;
    endcase
  end

  // FIFO storage; the policy tag is frozen here so later cfg_ext changes do not leak in
  always_ff @(posedge pClk) begin
    if (c0_enq_s) begin
      c0_hdr_mem_r[c0_wptr_r] <= c0_in_hdr;
      c0_ext_mem_r[c0_wptr_r] <= c0_in_is_rd ? cfg_ext : 3'b000;
      c0_rd_mem_r[c0_wptr_r]  <= c0_in_is_rd;
    end
    if (c1_enq_s) begin
      c1_hdr_mem_r[c1_wptr_r]  <= c1_in_hdr;
      c1_data_mem_r[c1_wptr_r] <= c1_in_data;
      c1_ext_mem_r[c1_wptr_r]  <= c1_in_is_wr ? cfg_ext : 3'b000;
    end
  end

  // Pointers, counts, registered outputs and sticky error state
  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      c0_wptr_r      <= '0;
      c0_rptr_r      <= '0;
      c0_count_r     <= '0;
      c1_wptr_r      <= '0;
      c1_rptr_r      <= '0;
      c1_count_r     <= '0;
      c0_out_valid_r <= 1'b0;
      c1_out_valid_r <= 1'b0;
      c0_out_hdr_r   <= '0;
      c0_out_ext_r   <= 3'b000;
      c1_out_hdr_r   <= '0;
      c1_out_data_r  <= '0;
      c1_out_ext_r   <= 3'b000;
      c0_almfull_r   <= 1'b0;
      c1_almfull_r   <= 1'b0;
      rd_out_r       <= '0;
      err_r          <= 2'b00;
    end else begin
      if (c0_enq_s) c0_wptr_r <= c0_wptr_r + AW'(1'b1);
      if (c0_deq_s) c0_rptr_r <= c0_rptr_r + AW'(1'b1);
      if (c1_enq_s) c1_wptr_r <= c1_wptr_r + AW'(1'b1);
      if (c1_deq_s) c1_rptr_r <= c1_rptr_r + AW'(1'b1);
      c0_count_r     <= c0_count_nxt_s;
      c1_count_r     <= c1_count_nxt_s;
      c0_out_valid_r <= c0_deq_s;
      c1_out_valid_r <= c1_deq_s;
      if (c0_deq_s) begin
        c0_out_hdr_r <= c0_hdr_mem_r[c0_rptr_r];
        c0_out_ext_r <= c0_ext_mem_r[c0_rptr_r];
      end
      if (c1_deq_s) begin
        c1_out_hdr_r  <= c1_hdr_mem_r[c1_rptr_r];
        c1_out_data_r <= c1_data_mem_r[c1_rptr_r];
        c1_out_ext_r  <= c1_ext_mem_r[c1_rptr_r];
      end
      c0_almfull_r <= (c0_count_nxt_s >= AF_THR_N);
      c1_almfull_r <= (c1_count_nxt_s >= AF_THR_N);
      rd_out_r     <= rd_out_nxt_s;
      err_r        <= err_r | {udf_s, c0_ovf_s | c1_ovf_s};
    end
  end

  assign c0_out_valid   = c0_out_valid_r;
  assign c0_out_hdr     = c0_out_hdr_r;
  assign c0_out_ext     = c0_out_ext_r;
  assign c0_almfull     = c0_almfull_r;
  assign c1_out_valid   = c1_out_valid_r;
  assign c1_out_hdr     = c1_out_hdr_r;
  assign c1_out_data    = c1_out_data_r;
  assign c1_out_ext     = c1_out_ext_r;
  assign c1_almfull     = c1_almfull_r;
  assign rd_outstanding = rd_out_r;
  assign err_flags      = err_r;

endmodule

// File: tb/tb_mpf_tx_policy_shim.sv
// Bench for mpf_tx_policy_shim: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_mpf_tx_policy_shim;

  localparam int HDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH = 8;
  localparam int SLACK = 4;
  localparam int MAXRD = 2;
  localparam int CW = $clog2(MAXRD + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] cfg_ext;
  logic c0_in_valid, c0_in_is_rd, fiu_c0_almfull, c0_rsp_valid;
  logic [HDR_W-1:0] c0_in_hdr;
  logic c1_in_valid, c1_in_is_wr, fiu_c1_almfull;
  logic [HDR_W-1:0] c1_in_hdr;
  logic [DATA_W-1:0] c1_in_data;
  logic c0_almfull, c0_out_valid, c1_almfull, c1_out_valid;
  logic [HDR_W-1:0] c0_out_hdr, c1_out_hdr;
  logic [2:0] c0_out_ext, c1_out_ext;
  logic [DATA_W-1:0] c1_out_data;
  logic [CW-1:0] rd_outstanding;
  logic [1:0] err_flags;

  mpf_tx_policy_shim #(
    .HDR_W(HDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .ALMFULL_SLACK(SLACK), .MAX_RD_OUT(MAXRD)
  ) dut (
    .pClk(clk), .SoftReset_n(rst_n), .cfg_ext(cfg_ext),
    .c0_in_valid(c0_in_valid), .c0_in_is_rd(c0_in_is_rd), .c0_in_hdr(c0_in_hdr),
    .c0_almfull(c0_almfull), .c0_out_valid(c0_out_valid), .c0_out_hdr(c0_out_hdr),
    .c0_out_ext(c0_out_ext), .fiu_c0_almfull(fiu_c0_almfull), .c0_rsp_valid(c0_rsp_valid),
    .c1_in_valid(c1_in_valid), .c1_in_is_wr(c1_in_is_wr), .c1_in_hdr(c1_in_hdr),
    .c1_in_data(c1_in_data), .c1_almfull(c1_almfull), .c1_out_valid(c1_out_valid),
    .c1_out_hdr(c1_out_hdr), .c1_out_data(c1_out_data), .c1_out_ext(c1_out_ext),
    .fiu_c1_almfull(fiu_c1_almfull), .rd_outstanding(rd_outstanding), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_rd; logic [2:0] ext; logic [HDR_W-1:0] hdr; } e0_t;
  typedef struct packed { logic [2:0] ext; logic [HDR_W-1:0] hdr; logic [DATA_W-1:0] data; } e1_t;

  e0_t q0[$];
  e1_t q1[$];
  logic m_c0_valid, m_c1_valid, m_af0, m_af1;
  logic [HDR_W-1:0] m_c0_hdr, m_c1_hdr;
  logic [2:0] m_c0_ext, m_c1_ext;
  logic [DATA_W-1:0] m_c1_data;
  int m_rdo;
  logic [1:0] m_err;
  int n_checks = 0;
  int n_errors = 0;
  int seen;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge evaluated from the pre-edge queue state
  task automatic model_step();
    logic d0, d1, a0, a1, rdq;
    e0_t h0, n0;
    e1_t h1, n1;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      m_c0_valid = 1'b0; m_c1_valid = 1'b0;
      m_af0 = 1'b0; m_af1 = 1'b0; m_rdo = 0; m_err = 2'b00;
    end else begin
      d0 = (q0.size() > 0) && !fiu_c0_almfull && (!q0[0].is_rd || m_rdo < MAXRD);
      d1 = (q1.size() > 0) && !fiu_c1_almfull;
      a0 = c0_in_valid && (q0.size() < DEPTH || d0);
      a1 = c1_in_valid && (q1.size() < DEPTH || d1);
      if ((c0_in_valid && !a0) || (c1_in_valid && !a1)) m_err[0] = 1'b1;
      m_c0_valid = d0;
      m_c1_valid = d1;
      rdq = 1'b0;
      if (d0) begin
        h0 = q0.pop_front();
        m_c0_hdr = h0.hdr; m_c0_ext = h0.ext; rdq = h0.is_rd;
      end
      if (d1) begin
        h1 = q1.pop_front();
        m_c1_hdr = h1.hdr; m_c1_ext = h1.ext; m_c1_data = h1.data;
      end
      if (a0) begin
        n0.is_rd = c0_in_is_rd; n0.ext = c0_in_is_rd ? cfg_ext : 3'b000; n0.hdr = c0_in_hdr;
        q0.push_back(n0);
      end
      if (a1) begin
        n1.ext = c1_in_is_wr ? cfg_ext : 3'b000; n1.hdr = c1_in_hdr; n1.data = c1_in_data;
        q1.push_back(n1);
      end
      if (rdq && !c0_rsp_valid) m_rdo++;
      else if (!rdq && c0_rsp_valid) begin
        if (m_rdo == 0) m_err[1] = 1'b1;
        else m_rdo--;
      end
      m_af0 = (q0.size() >= DEPTH - SLACK);
      m_af1 = (q1.size() >= DEPTH - SLACK);
    end
  endtask

  task automatic compare();
    check_eq("c0_valid", 64'(c0_out_valid), 64'(m_c0_valid));
    if (m_c0_valid) begin
      check_eq("c0_hdr", 64'(c0_out_hdr), 64'(m_c0_hdr));
      check_eq("c0_ext", 64'(c0_out_ext), 64'(m_c0_ext));
    end
    check_eq("c1_valid", 64'(c1_out_valid), 64'(m_c1_valid));
    if (m_c1_valid) begin
      check_eq("c1_hdr", 64'(c1_out_hdr), 64'(m_c1_hdr));
      check_eq("c1_data", 64'(c1_out_data), 64'(m_c1_data));
      check_eq("c1_ext", 64'(c1_out_ext), 64'(m_c1_ext));
    end
    check_eq("c0_almfull", 64'(c0_almfull), 64'(m_af0));
    check_eq("c1_almfull", 64'(c1_almfull), 64'(m_af1));
    check_eq("rd_outstanding", 64'(rd_outstanding), 64'(m_rdo));
    check_eq("err_flags", 64'(err_flags), 64'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    c0_in_valid = 1'b0; c0_in_is_rd = 1'b0; c0_rsp_valid = 1'b0; fiu_c0_almfull = 1'b0;
    c1_in_valid = 1'b0; c1_in_is_wr = 1'b0; fiu_c1_almfull = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_ext = 3'b000; c0_in_hdr = '0; c1_in_hdr = '0; c1_in_data = '0;
    idle();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Single read, two-cycle latency, tag 101
    cfg_ext = 3'b101; c0_in_valid = 1'b1; c0_in_is_rd = 1'b1; c0_in_hdr = 16'h0A01;
    cycle();
    c0_in_valid = 1'b0;
    cycle();
    check_eq("t24_valid", 64'(c0_out_valid), 64'd1);
    check_eq("t24_ext", 64'(c0_out_ext), 64'h5);
    check_eq("t24_rdo", 64'(rd_outstanding), 64'd1);
    c0_rsp_valid = 1'b1; cycle(); c0_rsp_valid = 1'b0;

    // Nine back-to-back writes into a blocked channel
    fiu_c1_almfull = 1'b1;
    for (int i = 0; i < 9; i++) begin
      c1_in_valid = 1'b1; c1_in_is_wr = 1'b1; c1_in_hdr = 16'h2500 + 16'(i); c1_in_data = $urandom;
      cycle();
      if (i == 2) check_eq("t25_af_lo", 64'(c1_almfull), 64'd0);
      if (i == 3) check_eq("t25_af_hi", 64'(c1_almfull), 64'd1);
    end
    c1_in_valid = 1'b0;
    check_eq("t25_err", 64'(err_flags), 64'h1);
    fiu_c1_almfull = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin cycle(); if (c1_out_valid) seen++; end
    check_eq("t25_outputs", 64'(seen), 64'd8);

    // Read cap of two with no responses
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      c0_in_valid = 1'b1; c0_in_is_rd = 1'b1; c0_in_hdr = 16'h2600 + 16'(i);
      cycle(); if (c0_out_valid) seen++;
    end
    c0_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin cycle(); if (c0_out_valid) seen++; end
    check_eq("t26_issued", 64'(seen), 64'd2);
    check_eq("t26_rdo_cap", 64'(rd_outstanding), 64'd2);
    c0_rsp_valid = 1'b1; cycle(); c0_rsp_valid = 1'b0;
    check_eq("t26_held", 64'(c0_out_valid), 64'd0);
    cycle();
    check_eq("t26_third", 64'(c0_out_valid), 64'd1);
    check_eq("t26_third_hdr", 64'(c0_out_hdr), 64'h2602);
    check_eq("t26_rdo", 64'(rd_outstanding), 64'd2);

    // Same-cycle dequeue and response, then underflow at zero
    c0_rsp_valid = 1'b1; cycle(); c0_rsp_valid = 1'b0;
    c0_in_valid = 1'b1; c0_in_is_rd = 1'b1; c0_in_hdr = 16'h2700;
    cycle();
    c0_in_valid = 1'b0; c0_rsp_valid = 1'b1;
    cycle();
    check_eq("t27_deq", 64'(c0_out_valid), 64'd1);
    check_eq("t27_same", 64'(rd_outstanding), 64'd1);
    cycle();
    cycle();
    c0_rsp_valid = 1'b0;
    check_eq("t27_zero", 64'(rd_outstanding), 64'd0);
    check_eq("t27_udf", 64'(err_flags[1]), 64'd1);

    // Tag masking for non-reads and tag frozen at enqueue
    cfg_ext = 3'b111; c0_in_valid = 1'b1; c0_in_is_rd = 1'b0; c0_in_hdr = 16'h2800;
    cycle();
    c0_in_valid = 1'b0;
    cycle();
    check_eq("t28_nonrd_ext", 64'(c0_out_ext), 64'h0);
    fiu_c0_almfull = 1'b1; cfg_ext = 3'b010;
    c0_in_valid = 1'b1; c0_in_is_rd = 1'b1; c0_in_hdr = 16'h2801;
    cycle();
    c0_in_valid = 1'b0; cfg_ext = 3'b111;
    repeat (2) cycle();
    fiu_c0_almfull = 1'b0;
    cycle();
    check_eq("t28_frozen_valid", 64'(c0_out_valid), 64'd1);
    check_eq("t28_frozen_ext", 64'(c0_out_ext), 64'h2);
    c0_rsp_valid = 1'b1; cycle(); c0_rsp_valid = 1'b0;

    // Mid-operation reset discards queued entries
    fiu_c1_almfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c1_in_valid = 1'b1; c1_in_is_wr = 1'b1; c1_in_hdr = 16'h2900 + 16'(i); c1_in_data = $urandom;
      cycle();
    end
    c1_in_valid = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; fiu_c1_almfull = 1'b0;
    check_eq("t29_err_clr", 64'(err_flags), 64'h0);
    check_eq("t29_af_clr", 64'(c1_almfull), 64'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin cycle(); if (c1_out_valid) seen++; end
    check_eq("t29_no_stale", 64'(seen), 64'd0);
    c0_rsp_valid = 1'b1; cycle(); c0_rsp_valid = 1'b0;
    check_eq("t29_post_rst_udf", 64'(err_flags), 64'h2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0) cfg_ext = 3'($urandom);
      c0_in_valid = ($urandom_range(0, 99) < 45);
      c0_in_is_rd = ($urandom_range(0, 3) != 0);
      c0_in_hdr = 16'($urandom);
      fiu_c0_almfull = ($urandom_range(0, 99) < 25);
      c0_rsp_valid = (m_rdo > 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 2);
      c1_in_valid = ($urandom_range(0, 99) < 50);
      c1_in_is_wr = ($urandom_range(0, 3) != 0);
      c1_in_hdr = 16'($urandom);
      c1_in_data = $urandom;
      fiu_c1_almfull = ($urandom_range(0, 99) < 40);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
